// File: rtl/pc_next_sel_unit.sv
// pc_next_sel_unit
//   Registered fetch program counter with prioritised next-PC selection.
//   Redirect sources, highest priority first: flush vector, ALU branch target,
//   jump/call target, return-address-stack top. With no request the PC
//   advances by PC_INC, or takes a redirect that was captured while stalled.
//
//   Optional feature macro: PC_RAS_EN
//     defined   : RAS_DEPTH-entry circular return-address stack.
//     undefined : no stack; call_en acts as a plain jump, ret_en is ignored,
//                 ras_underflow is tied to 0.
//
// Ports
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   stall          hold pc_out; winning request is captured as pending
//   flush_en       redirect to flush_vector
//   branch_taken   redirect to output_ALU
//   jump_en        redirect to jump_target (call_en marks it as a call)
//   ret_en         redirect to the return-address-stack top
//   pc_out         current fetch PC
//   pc_plus_inc    pc_out + PC_INC (combinational, wraps)
//   redirect       pc_out was loaded non-sequentially on the last edge
//   pending_valid  a captured redirect waits for stall release
//   ras_underflow  one-cycle pulse: ret_en won with the stack empty
module pc_next_sel_unit #(
    parameter int unsigned         PC_WIDTH  = 48,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter logic [PC_WIDTH-1:0] PC_INC    = PC_WIDTH'(1),
    parameter int unsigned         RAS_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                flush_en,
    input  logic [PC_WIDTH-1:0] flush_vector,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] output_ALU,
    input  logic                jump_en,
    input  logic                call_en,
    input  logic [PC_WIDTH-1:0] jump_target,
    input  logic                ret_en,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic [PC_WIDTH-1:0] pc_plus_inc,
    output logic                redirect,
    output logic                pending_valid,
    output logic                ras_underflow
);

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] pend_q, pend_d;
    logic                pend_valid_q, pend_valid_d;
    logic                redirect_q, redirect_d;

    logic                req_valid;
    logic [PC_WIDTH-1:0] req_target;

    assign pc_plus_inc = pc_q + PC_INC;

`ifdef PC_RAS_EN
    localparam int unsigned IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [PC_WIDTH-1:0] ras_mem_q [RAS_DEPTH];
    logic [IDX_W-1:0]    ras_head_q;   // next slot to write
    logic [CNT_W-1:0]    ras_cnt_q;    // valid entries, saturates at RAS_DEPTH
    logic [IDX_W-1:0]    ras_top_idx;
    logic                ras_empty, ras_full;
    logic                ras_push, ras_pop, ras_uflow;
    logic                ras_uflow_q;

    // Head wraps modulo RAS_DEPTH (power of two), so a push on a full stack
    // silently overwrites the oldest entry.
    assign ras_top_idx = ras_head_q - IDX_W'(1);
    assign ras_empty   = (ras_cnt_q == '0);
    assign ras_full    = (ras_cnt_q == CNT_W'(RAS_DEPTH));
`else
    logic unused_ras;
    localparam int unsigned unused_ras_depth = RAS_DEPTH;
    assign unused_ras = &{1'b0, call_en, ret_en};
`endif

    // Request arbitration; losing requests cause no push/pop.
    always_comb begin
        req_valid  = 1'b0;
        req_target = '0;
`ifdef PC_RAS_EN
        ras_push   = 1'b0;
        ras_pop    = 1'b0;
        ras_uflow  = 1'b0;
`endif
        if (flush_en) begin
            req_valid  = 1'b1;
            req_target = flush_vector;
        end else if (branch_taken) begin
            req_valid  = 1'b1;
            req_target = output_ALU;
        end else if (jump_en) begin
            req_valid  = 1'b1;
            req_target = jump_target;
`ifdef PC_RAS_EN
            ras_push   = call_en;
`endif
        end
`ifdef PC_RAS_EN
        else if (ret_en) begin
            if (ras_empty) begin
                ras_uflow = 1'b1;
            end else begin
                req_valid  = 1'b1;
                req_target = ras_mem_q[ras_top_idx];
                ras_pop    = 1'b1;
            end
        end
`endif
    end

    // A stalled edge parks the winning target; any unstalled edge consumes it.
    always_comb begin
        pc_d         = pc_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        redirect_d   = 1'b0;
        if (stall) begin
            if (req_valid) begin
                pend_d       = req_target;
                pend_valid_d = 1'b1;
            end
        end else begin
            pend_valid_d = 1'b0;
            if (req_valid) begin
                pc_d       = req_target;
                redirect_d = 1'b1;
            end else if (pend_valid_q) begin
                pc_d       = pend_q;
                redirect_d = 1'b1;
            end else begin
                pc_d = pc_plus_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            redirect_q   <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            redirect_q   <= redirect_d;
        end
    end

`ifdef PC_RAS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ras_head_q  <= '0;
            ras_cnt_q   <= '0;
            ras_uflow_q <= 1'b0;
        end else begin
            ras_uflow_q <= ras_uflow;
            if (ras_push) begin
                ras_head_q <= ras_head_q + IDX_W'(1);
                if (!ras_full) begin
                    ras_cnt_q <= ras_cnt_q + CNT_W'(1);
                end
            end else if (ras_pop) begin
                ras_head_q <= ras_top_idx;
                ras_cnt_q  <= ras_cnt_q - CNT_W'(1);
            end
        end
    end

    // Entry storage needs no reset: the count alone marks what is valid.
    always_ff @(posedge clk) begin
        if (ras_push) begin
            ras_mem_q[ras_head_q] <= pc_plus_inc;
        end
    end

    assign ras_underflow = ras_uflow_q;
`else
    assign ras_underflow = 1'b0;
`endif

    assign pc_out        = pc_q;
    assign redirect      = redirect_q;
    assign pending_valid = pend_valid_q;

endmodule
